// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper and the 4-input logic block it characterises.
// The master side is the sweeper. The slave side is the environment: it issues start,
// returns X, and observes the stimulus and the captured table.
interface truth_table_sweeper_if;
    logic        start;
    logic        X;
    logic        A;
    logic        B;
    logic        C;
    logic        D;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        table_valid;

    modport master (
        input  start,
        input  X,
        output A,
        output B,
        output C,
        output D,
        output busy,
        output done,
        output table_out,
        output table_valid
    );

    modport slave (
        output start,
        output X,
        input  A,
        input  B,
        input  C,
        input  D,
        input  busy,
        input  done,
        input  table_out,
        input  table_valid
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper.
// The sweeper walks {A,B,C,D} through 0..15 and holds each combination for
// SETTLE_CYCLES settle cycles plus one sample cycle. On the sample cycle it captures
// the X returned by the block under test into table_out[index]. When the sweep
// completes, it pulses done and keeps the table valid until the next accepted start.
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.master bus
);

    // A value of 0 behaves as 1. Values above 15 are clamped so that the 4-bit settle
    // counter can always reach its terminal count.
    localparam int         LP_SETTLE_EFF = (SETTLE_CYCLES < 1)  ? 1  :
                                           (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam logic [3:0] LP_CNT_LAST   = 4'(LP_SETTLE_EFF - 1);
    localparam logic [3:0] LP_INDEX_LAST = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_index;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_valid;
    logic [15:0] r_table;

    // Sweep sequencer: state, index, settle count, captured table and all status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_index <= 4'd0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_table <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Index is already 0 here, so the stimulus idles at 4'b0000.
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_SETTLE;
                        r_index <= 4'd0;
                        r_cnt   <= 4'd0;
                        r_table <= 16'h0000;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == LP_CNT_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end

                S_SAMPLE: begin
                    // X is sampled only in this state. Changes on X while settling are ignored.
                    r_table[r_index] <= bus.X;
                    if (r_index == LP_INDEX_LAST) begin
                        // The index stops at 15 and never wraps within a sweep.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_valid <= 1'b1;
                    end else begin
                        r_index <= r_index + 4'd1;
                        r_cnt   <= 4'd0;
                        r_state <= S_SETTLE;
                    end
                end

                S_DONE: begin
                    // start is not looked at here, so a request in this cycle is dropped.
                    r_done  <= 1'b0;
                    r_index <= 4'd0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_index <= 4'd0;
                    r_cnt   <= 4'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A           = r_index[3];
    assign bus.B           = r_index[2];
    assign bus.C           = r_index[1];
    assign bus.D           = r_index[0];
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.table_out   = r_table;
    assign bus.table_valid = r_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper.
// Two instances are used, with SETTLE_CYCLES = 4 and SETTLE_CYCLES = 1. The block under
// test is modelled as a 16-entry truth table indexed by {A,B,C,D}. Optional random
// glitches on X during the settle cycles must never reach the captured table.
module tb_truth_table_sweeper;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    truth_table_sweeper_if bus4 ();
    truth_table_sweeper_if bus1 ();

    truth_table_sweeper #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // The second instance always characterises an AND4 block.
    assign bus1.X = bus1.A & bus1.B & bus1.C & bus1.D;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Truth table of a named boolean function of {A,B,C,D}, where A is the MSB.
    // Kinds: 0 = AND4, 1 = XOR4, 2 = A, 3 = constant 1.
    function automatic logic [15:0] truth(input int kind);
        logic [15:0] t;
        logic [3:0]  v;
        t = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            case (kind)
                0:       t[i] = v[3] & v[2] & v[1] & v[0];
                1:       t[i] = v[3] ^ v[2] ^ v[1] ^ v[0];
                2:       t[i] = v[3];
                default: t[i] = 1'b1;
            endcase
        end
        return t;
    endfunction

    function automatic logic [31:0] outs4();
        return {9'd0, bus4.A, bus4.B, bus4.C, bus4.D, bus4.busy, bus4.done,
                bus4.table_valid, bus4.table_out};
    endfunction

    function automatic logic [31:0] outs1();
        return {9'd0, bus1.A, bus1.B, bus1.C, bus1.D, bus1.busy, bus1.done,
                bus1.table_valid, bus1.table_out};
    endfunction

    // Runs one sweep on the SETTLE_CYCLES=4 instance and checks it cycle by cycle.
    // The caller raises start4 at a negedge before calling. The next posedge is the
    // start edge. k counts cycles from the start edge. Combination i owns cycles
    // 5i..5i+4, and cycle 5i+4 is the sample cycle. DONE is cycle 80 and IDLE is cycle 81.
    // If abort_k >= 0, rst is raised between edges in that cycle and the task returns.
    task automatic sweep4(input logic [15:0] drive_f, input logic [15:0] exp_f,
                          input bit noise, input bit repulse, input int abort_k);
        logic [3:0]  a;
        logic [15:0] partial;
        int          idx;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        for (int k = 0; k <= 81; k++) begin
            a = {bus4.A, bus4.B, bus4.C, bus4.D};
            if (k == abort_k) begin
                #2 rst = 1'b1;
                #1;
                check("async_rst_outputs", outs4(), 32'd0);
                return;
            end
            if (k < 80) begin
                idx     = k / 5;
                partial = exp_f & ((16'h0001 << idx) - 16'h0001);
                check("sweep_abcd", {28'd0, a}, 32'(idx));
                check("sweep_busy", {31'd0, bus4.busy}, 32'd1);
                check("sweep_done", {31'd0, bus4.done}, 32'd0);
                check("sweep_valid", {31'd0, bus4.table_valid}, 32'd0);
                check("sweep_partial_table", {16'd0, bus4.table_out}, {16'd0, partial});
            end else if (k == 80) begin
                check("done_pulse", {31'd0, bus4.done}, 32'd1);
                check("done_busy", {31'd0, bus4.busy}, 32'd0);
                check("done_valid", {31'd0, bus4.table_valid}, 32'd1);
                check("done_table", {16'd0, bus4.table_out}, {16'd0, exp_f});
            end else begin
                check("idle_done_low", {31'd0, bus4.done}, 32'd0);
                check("idle_busy", {31'd0, bus4.busy}, 32'd0);
                check("idle_abcd", {28'd0, a}, 32'd0);
                check("idle_valid_hold", {31'd0, bus4.table_valid}, 32'd1);
                check("idle_table_hold", {16'd0, bus4.table_out}, {16'd0, exp_f});
            end
            bus4.start = repulse && (k == 25 || k == 80);
            bus4.X = drive_f[a] ^ (noise && (k % 5 != 4) && ($urandom_range(0, 1) == 1));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] f;
        int          found;
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        bus4.X     = 1'b0;
        bus4.start = 1'b1;    // held through reset; it must be taken on the first edge after release
        bus1.start = 1'b0;

        // Reset takes effect before any clock edge.
        #1;
        check("reset_outs4", outs4(), 32'd0);
        check("reset_outs1", outs1(), 32'd0);
        repeat (2) @(negedge clk);
        check("reset_hold_outs4", outs4(), 32'd0);
        rst = 1'b0;

        // AND4 sweep, started by the start request held through reset.
        sweep4(truth(0), 16'h8000, 1'b0, 1'b0, -1);

        // XOR4 sweep with glitches on X during the settle cycles.
        @(negedge clk); bus4.start = 1'b1;
        sweep4(truth(1), 16'h6996, 1'b1, 1'b0, -1);

        // X = A, then X tied to 1. The second start clears table_valid and the table.
        @(negedge clk); bus4.start = 1'b1;
        sweep4(truth(2), 16'hFF00, 1'b0, 1'b0, -1);
        @(negedge clk); bus4.start = 1'b1;
        sweep4(truth(3), 16'hFFFF, 1'b0, 1'b0, -1);

        // start pulsed again at index 5 and in the DONE cycle is ignored.
        @(negedge clk); bus4.start = 1'b1;
        sweep4(truth(1), 16'h6996, 1'b0, 1'b1, -1);
        repeat (3) @(negedge clk);
        check("no_restart_busy", {31'd0, bus4.busy}, 32'd0);

        // Asynchronous reset at index 7, then a full random sweep afterwards.
        f = 16'($urandom);
        @(negedge clk); bus4.start = 1'b1;
        sweep4(f, f, 1'b1, 1'b0, 37);
        bus4.start = 1'b0;
        @(posedge clk); #1;
        check("rst_held_outs4", outs4(), 32'd0);
        @(negedge clk); rst = 1'b0;
        f = 16'($urandom);
        @(negedge clk); bus4.start = 1'b1;
        sweep4(f, f, 1'b1, 1'b0, -1);

        // Further random truth tables, with glitches.
        for (int r = 0; r < 2; r++) begin
            f = 16'($urandom);
            @(negedge clk); bus4.start = 1'b1;
            sweep4(f, f, 1'b1, 1'b0, -1);
        end

        // SETTLE_CYCLES = 1: each combination lasts 2 cycles, and done comes 32 cycles after start.
        @(negedge clk); bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk); bus1.start = 1'b0;
        found = -1;
        for (int k = 0; k <= 40; k++) begin
            if (k < 32) begin
                check("s1_abcd", {28'd0, bus1.A, bus1.B, bus1.C, bus1.D}, 32'(k / 2));
            end
            if (bus1.done === 1'b1 && found < 0) found = k;
            @(negedge clk);
        end
        check("s1_done_cycle", 32'(found), 32'd32);
        check("s1_table", {16'd0, bus1.table_out}, 32'h0000_8000);
        check("s1_valid", {31'd0, bus1.table_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
